// File: rtl/nes_bus_pkg.sv
// Shared NES bus constants and the OAM DMA state encoding.
package nes_bus_pkg;

   localparam logic [15:0] DMA_REG  = 16'h4014;
   localparam logic [15:0] OAM_PORT = 16'h2004;
   localparam int unsigned NBYTES   = 256;
   localparam logic [7:0]  LAST_IDX = 8'(NBYTES - 1);

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE
   } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// $4014 sprite DMA: snoops CPU writes, halts the CPU and copies one 256-byte
// SRAM page to PPU OAMDATA, one byte per READ/WRITE pair of CPU cycles.
module oam_dma
   import nes_bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_ce,
   input  logic [15:0] cpu_ea,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_wreq,
   output logic        dma_active,
   output logic [15:0] dma_addr,
   input  logic [7:0]  dma_din,
   output logic [15:0] dma_ea,
   output logic [7:0]  dma_wdata,
   output logic        dma_wreq,
   output logic        dma_done
);

   dma_state_t  state;
   dma_state_t  state_nxt;

   logic [7:0]  page;
   logic [7:0]  cnt;
   logic [7:0]  wbuf;
   logic [15:0] ea_hold;
   logic [7:0]  wdata_hold;
   logic        parity;
   logic        read_seen;
   logic        done_q;
   logic        dma_hit;
   logic        last_byte;

   assign dma_hit   = cpu_wreq && (cpu_ea == DMA_REG);
   assign last_byte = (cnt == LAST_IDX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else if (cpu_ce) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (dma_hit) state_nxt = HALT;
         HALT:    state_nxt = parity ? ALIGN : READ;
         ALIGN:   state_nxt = READ;
         READ:    state_nxt = WRITE;
         WRITE:   state_nxt = last_byte ? IDLE : READ;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      dma_active = (state != IDLE);
      dma_wreq   = (state == WRITE);
      dma_addr   = {page, cnt};
      dma_ea     = ea_hold;
      dma_wdata  = wdata_hold;
      dma_done   = done_q;
      if (state == WRITE) begin
         dma_ea    = OAM_PORT;
         dma_wdata = wbuf;
      end
   end

   // SRAM data is registered, so wbuf loads from the second clk of READ onward;
   // this needs cpu_ce pulses at least two clks apart.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parity     <= 1'b0;
         page       <= '0;
         cnt        <= '0;
         wbuf       <= '0;
         ea_hold    <= '0;
         wdata_hold <= '0;
         read_seen  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         read_seen <= (state == READ);
         done_q    <= cpu_ce && (state == WRITE) && last_byte;
         if (read_seen) begin
            wbuf <= dma_din;
         end
         if (state == WRITE) begin
            ea_hold    <= OAM_PORT;
            wdata_hold <= wbuf;
         end
         if (cpu_ce) begin
            parity <= ~parity;
            if (state == IDLE && dma_hit) begin
               page <= cpu_dout;
               cnt  <= '0;
            end
            if (state == WRITE) begin
               cnt <= cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: table of DMA transfers plus reset-mid-transfer sequence.
module tb_oam_dma;

   logic        clk;
   logic        reset;
   logic        cpu_ce;
   logic [15:0] cpu_ea;
   logic [7:0]  cpu_dout;
   logic        cpu_wreq;
   logic        dma_active;
   logic [15:0] dma_addr;
   logic [7:0]  dma_din;
   logic [15:0] dma_ea;
   logic [7:0]  dma_wdata;
   logic        dma_wreq;
   logic        dma_done;

   oam_dma dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_ce     (cpu_ce),
      .cpu_ea     (cpu_ea),
      .cpu_dout   (cpu_dout),
      .cpu_wreq   (cpu_wreq),
      .dma_active (dma_active),
      .dma_addr   (dma_addr),
      .dma_din    (dma_din),
      .dma_ea     (dma_ea),
      .dma_wdata  (dma_wdata),
      .dma_wreq   (dma_wreq),
      .dma_done   (dma_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // registered SRAM model
   logic [7:0] mem [0:65535];
   always @(posedge clk) dma_din <= mem[dma_addr];

   int          n_vec;
   int          n_bad;
   bit          ce_par;

   // bus monitor
   logic [15:0] wr_ea   [0:299];
   logic [7:0]  wr_data [0:299];
   int          wr_n;
   int          bad_bus;
   int          done_n;
   logic [15:0] last_addr;
   logic        wreq_q;

   always @(negedge clk) begin
      if (dma_wreq && !wreq_q && wr_n < 300) begin
         wr_ea[wr_n]   = dma_ea;
         wr_data[wr_n] = dma_wdata;
         wr_n++;
      end
      wreq_q = dma_wreq;
      if (dma_wreq && !dma_active) bad_bus++;
      if (dma_active && dma_addr == 16'h0000) bad_bus++;
      if (dma_active) last_addr = dma_addr;
      if (dma_done) done_n++;
   end

   typedef struct {
      logic [7:0]  page;
      bit          odd;
      int          rt_at;
      int          gmin;
      int          gmax;
      int          exp_cycles;
      int          exp_lat;
      int          exp_writes;
      logic [15:0] exp_last_addr;
      logic [7:0]  exp_first;
      logic [7:0]  exp_final;
   } vec_t;

   vec_t vecs [0:5];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp, output bit ok);
      n_vec++;
      ok = (act === exp);
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one CPU cycle: ce high for one clk, then gap-1 idle clks; returns at a negedge
   task automatic tick(input int gap, input logic wr, input logic [15:0] ea,
                       input logic [7:0] d);
      cpu_ce   = 1'b1;
      cpu_wreq = wr;
      cpu_ea   = ea;
      cpu_dout = d;
      @(negedge clk);
      cpu_ce   = 1'b0;
      cpu_wreq = 1'b0;
      ce_par   = ~ce_par;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic clear_mon();
      wr_n      = 0;
      bad_bus   = 0;
      done_n    = 0;
      last_addr = '0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  cycles;
      int  lat;
      bit  rt_done;
      bit  ok;
      int  g;
      clear_mon();
      // trigger parity 0 leaves parity 1 at HALT, which inserts ALIGN
      if (ce_par != !v.odd) tick(v.gmin, 1'b0, 16'h0000, 8'h00);
      tick(v.gmin, 1'b1, 16'h4014, v.page);
      cycles  = 0;
      lat     = 0;
      rt_done = 0;
      for (int k = 1; k <= 700; k++) begin
         g = int'($urandom_range(v.gmax, v.gmin));
         if (v.rt_at >= 0 && !rt_done && wr_n == v.rt_at) begin
            rt_done = 1;
            tick(g, 1'b1, 16'h4014, 8'h07);
         end else begin
            tick(g, 1'b0, 16'h0000, 8'h00);
         end
         if (lat == 0 && wr_n > 0) lat = k;
         cycles = k;
         if (!dma_active) break;
      end
      check($sformatf("v%0d cycles", idx), cycles, v.exp_cycles, ok);
      check($sformatf("v%0d first_wreq_latency", idx), lat, v.exp_lat, ok);
      check($sformatf("v%0d write_count", idx), wr_n, v.exp_writes, ok);
      check($sformatf("v%0d first_byte", idx), wr_data[0], v.exp_first, ok);
      check($sformatf("v%0d final_byte", idx), wr_data[255], v.exp_final, ok);
      for (int k = 0; k < 256 && k < wr_n; k++) begin
         check($sformatf("v%0d byte%0d", idx, k), {wr_ea[k], wr_data[k]},
               {16'h2004, mem[{v.page, 8'(k)}]}, ok);
         if (!ok) break;
      end
      check($sformatf("v%0d last_read_addr", idx), last_addr, v.exp_last_addr, ok);
      check($sformatf("v%0d bus_violations", idx), bad_bus, 0, ok);
      check($sformatf("v%0d done_pulses", idx), done_n, 1, ok);
      check($sformatf("v%0d hold_after", idx), {dma_active, dma_wreq, dma_ea, dma_wdata},
            {1'b0, 1'b0, 16'h2004, v.exp_final}, ok);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit ok;
      n_vec    = 0;
      n_bad    = 0;
      ce_par   = 0;
      reset    = 1'b0;
      cpu_ce   = 1'b0;
      cpu_wreq = 1'b0;
      cpu_ea   = '0;
      cpu_dout = '0;
      wreq_q   = 1'b0;
      clear_mon();
      for (int i = 0; i < 65536; i++) mem[i] = 8'hC3;
      for (int i = 0; i < 256; i++) begin
         mem[{8'h02, 8'(i)}] = 8'(i);
         mem[{8'hFF, 8'(i)}] = ~8'(i);
         mem[{8'h07, 8'(i)}] = 8'(i) ^ 8'h5A;
      end
      mem[16'h0000] = 8'hEE;

      //          page  odd rt  gmin gmax cyc  lat wr   last      first  final
      vecs[0] = '{8'h02, 0, -1, 2,   2,   513, 2,  256, 16'h02FF, 8'h00, 8'hFF};
      vecs[1] = '{8'h02, 1, -1, 2,   2,   514, 3,  256, 16'h02FF, 8'h00, 8'hFF};
      vecs[2] = '{8'h02, 0, 40, 2,   2,   513, 2,  256, 16'h02FF, 8'h00, 8'hFF};
      vecs[3] = '{8'hFF, 0, -1, 3,   3,   513, 2,  256, 16'hFFFF, 8'hFF, 8'h00};
      vecs[4] = '{8'h02, 1, -1, 2,   20,  514, 3,  256, 16'h02FF, 8'h00, 8'hFF};
      vecs[5] = '{8'h02, 0, -1, 2,   2,   513, 2,  256, 16'h02FF, 8'h00, 8'hFF};

      repeat (3) @(negedge clk);
      check("reset_outputs", {dma_active, dma_addr, dma_ea, dma_wdata, dma_wreq, dma_done},
            64'h0, ok);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // reset in the middle of a transfer
      clear_mon();
      tick(2, 1'b1, 16'h4014, 8'h02);
      for (int k = 0; k < 400 && wr_n < 100; k++) tick(2, 1'b0, 16'h0000, 8'h00);
      check("rst_reached_byte100", wr_n, 100, ok);
      reset = 1'b0;
      #1;
      check("rst_outputs_cleared", {dma_active, dma_addr, dma_ea, dma_wdata, dma_wreq, dma_done},
            64'h0, ok);
      repeat (3) @(negedge clk);
      reset  = 1'b1;
      ce_par = 0;
      for (int k = 0; k < 4; k++) tick(2, 1'b0, 16'h0000, 8'h00);
      check("rst_stays_idle", {dma_active, dma_wreq}, 2'b00, ok);
      check("rst_no_more_writes", wr_n, 100, ok);
      run_vec(vecs[5], 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
